// File: rtl/multi_edge_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_edge_detector: per-channel synchroniser, debouncer and edge detector  |
// | with mode-qualified events, sticky pending flags and an OR-ed interrupt.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_edge_detector #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   level_in,
  input  logic [2*N-1:0] mode,
  input  logic [N-1:0]   clear,
  output logic [N-1:0]   level_out,
  output logic [N-1:0]   p_edge,
  output logic [N-1:0]   n_edge,
  output logic [N-1:0]   any_edge,
  // 'event' is a reserved word, so the mode-qualified pulse is edge_event
  output logic [N-1:0]   edge_event,
  output logic [N-1:0]   pending,
  output logic           irq
);

  localparam int                CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] chain;
    logic                   sync;
    logic [CNT_W-1:0]       count;
    logic                   level_q;
    logic                   prev_q;
    logic                   pend_q;
    logic                   rise;
    logic                   fall;
    logic                   evt;

    always_ff @(posedge clk) begin
      if (reset) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], level_in[i]};
      end
    end

    assign sync = chain[SYNC_STAGES-1];

    // Any sample matching the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
      if (reset) begin
        count   <= '0;
        level_q <= 1'b0;
      end else if (sync == level_q) begin
        count <= '0;
      end else if (count == DB_LAST) begin
        count   <= '0;
        level_q <= sync;
      end else begin
        count <= count + CNT_W'(1);
      end
    end

    assign rise = level_q & ~prev_q;
    assign fall = ~level_q & prev_q;
    assign evt  = (rise & mode[2*i]) | (fall & mode[2*i+1]);

    // Set has priority over clear so an event is never lost.
    always_ff @(posedge clk) begin
      if (reset) begin
        prev_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        prev_q <= level_q;
        pend_q <= evt | (pend_q & ~clear[i]);
      end
    end

    assign level_out[i]  = level_q;
    assign p_edge[i]     = rise;
    assign n_edge[i]     = fall;
    assign any_edge[i]   = rise | fall;
    assign edge_event[i] = evt;
    assign pending[i]    = pend_q;
  end

  assign irq = |pending;

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_edge_detector: checks a default 4-channel instance and a 1-channel |
// | SYNC=3/DB=1 instance against a sample-history reference model.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_edge_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] level_in_a, clear_a;
  logic [7:0] mode_a;
  logic [3:0] level_out_a, p_edge_a, n_edge_a, any_edge_a, edge_event_a, pending_a;
  logic       irq_a;

  logic [0:0] level_in_b, clear_b;
  logic [1:0] mode_b;
  logic [0:0] level_out_b, p_edge_b, n_edge_b, any_edge_b, edge_event_b, pending_b;
  logic       irq_b;

  multi_edge_detector #(.N(4), .SYNC_STAGES(2), .DB_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .level_in(level_in_a), .mode(mode_a), .clear(clear_a),
    .level_out(level_out_a), .p_edge(p_edge_a), .n_edge(n_edge_a), .any_edge(any_edge_a),
    .edge_event(edge_event_a), .pending(pending_a), .irq(irq_a)
  );

  multi_edge_detector #(.N(1), .SYNC_STAGES(3), .DB_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .level_in(level_in_b), .mode(mode_b), .clear(clear_b),
    .level_out(level_out_b), .p_edge(p_edge_b), .n_edge(n_edge_b), .any_edge(any_edge_b),
    .edge_event(edge_event_b), .pending(pending_b), .irq(irq_b)
  );

  // Reference model: bits [3:0] are instance A channels, bit 4 is instance B.
  localparam int HMAX = 8192;
  logic [4:0] samp [0:HMAX-1];
  int         k          = 0;
  int         last_reset = 0;
  logic [4:0] m_level    = '0;
  logic [4:0] m_prev     = '0;
  logic [4:0] m_pend     = '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchroniser output seen just before edge j: the input sampled s edges earlier,
  // or zero if that sample predates the last reset.
  function automatic logic sync_pre(int j, int ch, int s);
    if (j - s > last_reset) return samp[j-s][ch];
    return 1'b0;
  endfunction

  // A new level is accepted at edge kk when the last db synchronised samples
  // all differ from the current level and none of them precede the last reset.
  function automatic logic accept(int kk, int ch, int s, int db, logic lvl);
    for (int j = kk - db + 1; j <= kk; j++) begin
      if (j <= last_reset) return 1'b0;
      if (sync_pre(j, ch, s) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [4:0] model_event(logic [4:0] lvl, logic [4:0] prv);
    logic [4:0] ren, fen;
    ren = {mode_b[0], mode_a[6], mode_a[4], mode_a[2], mode_a[0]};
    fen = {mode_b[1], mode_a[7], mode_a[5], mode_a[3], mode_a[1]};
    return ((lvl & ~prv) & ren) | ((~lvl & prv) & fen);
  endfunction

  always @(posedge clk) begin : model_b
    logic [4:0] ev, nl;
    k = k + 1;
    if (k >= HMAX) begin
      $display("FAIL model_history: got %0d expected below %0d", k, HMAX);
      $fatal(1);
    end
    if (reset) begin
      last_reset = k;
      samp[k]    = '0;
      m_level    = '0;
      m_prev     = '0;
      m_pend     = '0;
    end else begin
      samp[k] = {level_in_b, level_in_a};
      ev      = model_event(m_level, m_prev);
      m_pend  = ev | (m_pend & ~{clear_b, clear_a});
      nl      = m_level;
      for (int ch = 0; ch < 5; ch++) begin
        if (accept(k, ch, (ch < 4) ? 2 : 3, (ch < 4) ? 4 : 1, m_level[ch]))
          nl[ch] = ~m_level[ch];
      end
      m_prev  = m_level;
      m_level = nl;
    end
  end

  task automatic check_all();
    logic [4:0] pe, ne, ev;
    pe = m_level & ~m_prev;
    ne = ~m_level & m_prev;
    ev = model_event(m_level, m_prev);
    check("a_level",   32'(level_out_a),  32'(m_level[3:0]));
    check("a_p_edge",  32'(p_edge_a),     32'(pe[3:0]));
    check("a_n_edge",  32'(n_edge_a),     32'(ne[3:0]));
    check("a_any",     32'(any_edge_a),   32'(pe[3:0] | ne[3:0]));
    check("a_event",   32'(edge_event_a), 32'(ev[3:0]));
    check("a_pending", 32'(pending_a),    32'(m_pend[3:0]));
    check("a_irq",     32'(irq_a),        32'(|m_pend[3:0]));
    check("b_level",   32'(level_out_b),  32'(m_level[4]));
    check("b_p_edge",  32'(p_edge_b),     32'(pe[4]));
    check("b_n_edge",  32'(n_edge_b),     32'(ne[4]));
    check("b_any",     32'(any_edge_b),   32'(pe[4] | ne[4]));
    check("b_event",   32'(edge_event_b), 32'(ev[4]));
    check("b_pending", 32'(pending_b),    32'(m_pend[4]));
    check("b_irq",     32'(irq_b),        32'(m_pend[4]));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int cnt;
    reset      = 1'b1;
    level_in_a = 4'hF;
    clear_a    = 4'h0;
    mode_a     = 8'hFF;
    level_in_b = 1'b0;
    clear_b    = 1'b0;
    mode_b     = 2'b11;

    // Input held high across reset release: rising edge after full latency.
    repeat (3) cycle();
    check("rst_level", 32'(level_out_a), 32'h0);
    check("rst_irq",   32'(irq_a),       32'h0);
    reset = 1'b0;
    repeat (5) begin
      cycle();
      check("rst_p_early", 32'(p_edge_a), 32'h0);
    end
    cycle();
    check("rst_p_lat6", 32'(p_edge_a), 32'hF);
    cycle();
    check("rst_p_once", 32'(p_edge_a),    32'h0);
    check("rst_lvl_hi", 32'(level_out_a), 32'hF);

    level_in_a = 4'h0;
    repeat (8) cycle();
    clear_a = 4'hF;
    cycle();
    clear_a = 4'h0;
    cycle();

    // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted.
    level_in_a = 4'h1;
    repeat (3) cycle();
    level_in_a = 4'h0;
    repeat (10) begin
      cycle();
      check("glitch3_lvl", 32'(level_out_a[0]), 32'h0);
    end
    check("glitch3_pend", 32'(pending_a), 32'h0);
    level_in_a = 4'h1;
    repeat (4) cycle();
    level_in_a = 4'h0;
    for (int it = 1; it <= 12; it++) begin
      cycle();
      check("glitch4_p", 32'(p_edge_a[0]), 32'(it == 2));
      check("glitch4_n", 32'(n_edge_a[0]), 32'(it == 6));
    end
    clear_a = 4'hF;
    cycle();
    clear_a = 4'h0;

    // Mode filtering: ch0 off, ch1 rise, ch2 fall, ch3 both.
    mode_a     = 8'b11_10_01_00;
    level_in_a = 4'hF;
    repeat (5) cycle();
    cycle();
    check("mode_rise_evt", 32'(edge_event_a), 32'b1010);
    check("mode_rise_p",   32'(p_edge_a),     32'hF);
    repeat (4) cycle();
    level_in_a = 4'h0;
    repeat (5) cycle();
    cycle();
    check("mode_fall_evt", 32'(edge_event_a), 32'b1100);
    check("mode_fall_n",   32'(n_edge_a),     32'hF);
    repeat (4) cycle();
    clear_a = 4'hF;
    cycle();
    clear_a = 4'h0;
    mode_a  = 8'hFF;
    cycle();

    // Pending / clear behaviour on ch2.
    level_in_a = 4'b0100;
    repeat (6) cycle();
    check("pc_event", 32'(edge_event_a), 32'b0100);
    cycle();
    check("pc_pend", 32'(pending_a), 32'b0100);
    check("pc_irq",  32'(irq_a),     32'h1);
    clear_a = 4'b0100;
    cycle();
    clear_a = 4'h0;
    check("pc_cleared", 32'(pending_a), 32'h0);
    check("pc_irq_low", 32'(irq_a),     32'h0);
    clear_a    = 4'b0100;
    level_in_a = 4'h0;
    repeat (6) cycle();
    cycle();
    check("pc_set_wins", 32'(pending_a), 32'b0100);
    cycle();
    clear_a = 4'h0;
    cycle();

    // Reset in the middle of a ch1 debounce window.
    level_in_a = 4'b0001;
    repeat (8) cycle();
    level_in_a = 4'b0011;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_lvl",  32'(level_out_a), 32'h0);
    check("mid_rst_pend", 32'(pending_a),   32'h0);
    repeat (5) begin
      cycle();
      check("mid_rst_noedge", 32'(any_edge_a), 32'h0);
    end
    cycle();
    check("mid_rst_reacq", 32'(p_edge_a), 32'b0011);
    repeat (3) cycle();

    // Instance B: SYNC=3, DB=1 gives 4-edge latency and accepts 2-cycle toggles.
    level_in_b = 1'b1;
    repeat (3) begin
      cycle();
      check("b_lat_early", 32'(p_edge_b), 32'h0);
    end
    cycle();
    check("b_lat4", 32'(p_edge_b), 32'h1);
    repeat (2) cycle();
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      level_in_b = ~level_in_b;
      repeat (2) begin
        cycle();
        cnt += int'(any_edge_b);
      end
    end
    repeat (6) begin
      cycle();
      cnt += int'(any_edge_b);
    end
    check("b_toggle_cnt", 32'(cnt), 32'd10);

    // Randomised traffic, every cycle checked against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) level_in_a[i] = ~level_in_a[i];
      if ($urandom_range(0, 2) == 0) level_in_b = ~level_in_b;
      if ($urandom_range(0, 49) == 0) mode_a = 8'($urandom);
      if ($urandom_range(0, 49) == 0) mode_b = 2'($urandom);
      clear_a = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clear_b = ($urandom_range(0, 7) == 0) ? 1'($urandom) : 1'b0;
      reset   = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
